// File: rtl/t_mem_writer.sv
// Write-side controller for the transposed weight memory: assembles INIT rows from a
// word stream and performs saturating read-modify-write of delta rows during UPDATE.
module t_mem_writer #(
    parameter int         BW_WEIGHTS  = 11,
    parameter int         NUM_TM_V    = 10,
    parameter int         NUM_TM_H    = 10,
    parameter int         BW_ADDR     = 4,
    parameter logic [2:0] INIT_CODE   = 3'd1,
    parameter logic [2:0] UPDATE_CODE = 3'd2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [2:0]                     state_signal,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [BW_WEIGHTS-1:0]          s_data,
    input  logic                           d_valid,
    output logic                           d_ready,
    input  logic [BW_WEIGHTS*NUM_TM_V-1:0] d_data,
    input  logic [BW_WEIGHTS*NUM_TM_V-1:0] rd_weights,
    output logic [BW_ADDR-1:0]             h_addr_read,
    output logic [BW_ADDR-1:0]             h_addr_write,
    output logic [BW_WEIGHTS*NUM_TM_V-1:0] wr_weights,
    output logic                           init_w_new,
    output logic                           update_write_en,
    output logic                           init_done,
    output logic                           update_done
);

    localparam int                 ROW_W    = BW_WEIGHTS * NUM_TM_V;
    localparam logic [BW_ADDR-1:0] LAST_COL = BW_ADDR'(NUM_TM_V - 1);
    localparam logic [BW_ADDR-1:0] LAST_ROW = BW_ADDR'(NUM_TM_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_COL,
        S_INIT_WR,
        S_UPD_RD,
        S_UPD_WR,
        S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [BW_ADDR-1:0] r_row, w_row_nxt;
    logic [BW_ADDR-1:0] r_col, w_col_nxt;
    logic [ROW_W-1:0]   r_wr_weights, w_wr_nxt;
    logic               r_init_done, w_init_done_nxt;
    logic               r_update_done, w_update_done_nxt;
    logic               w_is_init, w_is_upd;

    // Overflow shows up as disagreement between the two top bits of the widened sum.
    function automatic logic [BW_WEIGHTS-1:0] sat_add(input logic [BW_WEIGHTS-1:0] a,
                                                      input logic [BW_WEIGHTS-1:0] b);
        logic [BW_WEIGHTS:0] sum;
        sum = {a[BW_WEIGHTS-1], a} + {b[BW_WEIGHTS-1], b};
        if (sum[BW_WEIGHTS] != sum[BW_WEIGHTS-1])
            return sum[BW_WEIGHTS] ? {1'b1, {(BW_WEIGHTS-1){1'b0}}}
                                   : {1'b0, {(BW_WEIGHTS-1){1'b1}}};
        return sum[BW_WEIGHTS-1:0];
    endfunction

    assign w_is_init = (state_signal == INIT_CODE);
    assign w_is_upd  = (state_signal == UPDATE_CODE);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt       = r_state;
        w_row_nxt         = r_row;
        w_col_nxt         = r_col;
        w_wr_nxt          = r_wr_weights;
        w_init_done_nxt   = r_init_done;
        w_update_done_nxt = r_update_done;
        s_ready           = 1'b0;
        d_ready           = 1'b0;
        init_w_new        = 1'b0;
        update_write_en   = 1'b0;
        h_addr_read       = '0;
        h_addr_write      = '0;

        case (r_state)
            S_IDLE: begin
                w_row_nxt = '0;
                w_col_nxt = '0;
                if (w_is_init)     w_state_nxt = S_INIT_COL;
                else if (w_is_upd) w_state_nxt = S_UPD_RD;
            end
            S_INIT_COL: begin
                if (!w_is_init) begin
                    w_state_nxt = S_IDLE;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end else begin
                    s_ready = en;
                    if (s_valid) begin
                        for (int c = 0; c < NUM_TM_V; c++)
                            if (r_col == BW_ADDR'(c)) w_wr_nxt[c*BW_WEIGHTS +: BW_WEIGHTS] = s_data;
                        w_col_nxt = r_col + BW_ADDR'(1);
                        if (r_col == LAST_COL) w_state_nxt = S_INIT_WR;
                    end
                end
            end
            S_INIT_WR: begin
                w_col_nxt = '0;
                if (!w_is_init) begin
                    w_state_nxt = S_IDLE;
                    w_row_nxt   = '0;
                end else begin
                    init_w_new   = en;
                    h_addr_write = r_row;
                    w_row_nxt    = r_row + BW_ADDR'(1);
                    if (r_row == LAST_ROW) begin
                        w_state_nxt     = S_DONE;
                        w_init_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_INIT_COL;
                    end
                end
            end
            S_UPD_RD: begin
                if (!w_is_upd) begin
                    w_state_nxt = S_IDLE;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end else begin
                    d_ready     = en;
                    h_addr_read = r_row;
                    if (d_valid) begin
                        for (int c = 0; c < NUM_TM_V; c++)
                            w_wr_nxt[c*BW_WEIGHTS +: BW_WEIGHTS] =
                                sat_add(rd_weights[c*BW_WEIGHTS +: BW_WEIGHTS],
                                        d_data[c*BW_WEIGHTS +: BW_WEIGHTS]);
                        w_state_nxt = S_UPD_WR;
                    end
                end
            end
            S_UPD_WR: begin
                if (!w_is_upd) begin
                    w_state_nxt = S_IDLE;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end else begin
                    update_write_en = en;
                    h_addr_write    = r_row;
                    w_row_nxt       = r_row + BW_ADDR'(1);
                    if (r_row == LAST_ROW) begin
                        w_state_nxt       = S_DONE;
                        w_update_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_UPD_RD;
                    end
                end
            end
            S_DONE: begin
                // Leave once the mode that finished is no longer requested.
                if ((r_init_done && !w_is_init) || (r_update_done && !w_is_upd) ||
                    (!r_init_done && !r_update_done)) begin
                    w_state_nxt       = S_IDLE;
                    w_init_done_nxt   = 1'b0;
                    w_update_done_nxt = 1'b0;
                    w_row_nxt         = '0;
                    w_col_nxt         = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_wr_weights  <= '0;
            r_init_done   <= 1'b0;
            r_update_done <= 1'b0;
        end else if (en) begin
            r_state       <= w_state_nxt;
            r_row         <= w_row_nxt;
            r_col         <= w_col_nxt;
            r_wr_weights  <= w_wr_nxt;
            r_init_done   <= w_init_done_nxt;
            r_update_done <= w_update_done_nxt;
        end
    end

    assign wr_weights  = r_wr_weights;
    assign init_done   = r_init_done;
    assign update_done = r_update_done;

endmodule
